// File: rtl/nes_pkg.sv
// Shared NES pad definitions: serial bit order, frame length and pad FSM states.
package nes_pkg;

  // Number of bits in one NES controller frame.
  localparam int NES_BITS = 8;

  // Button positions within the parallel word and the serial stream.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // Width of the bit index output and its "frame drained" value.
  localparam int                   BIT_IDX_W   = 4;
  localparam logic [BIT_IDX_W-1:0] IDX_FIRST   = 4'd0;
  localparam logic [BIT_IDX_W-1:0] IDX_LAST    = 4'd7;
  localparam logic [BIT_IDX_W-1:0] IDX_DRAINED = 4'd8;

  // Pad emulator state machine.
  typedef enum logic [1:0] {
    DRAINED = 2'd0,
    LOAD    = 2'd1,
    SHIFT   = 2'd2
  } pad_state_t;

endpackage

// File: rtl/nes_pad_emulator_sync_edge.sv
// Multi-stage synchronizer for one asynchronous host pin with a registered
// edge detector producing single-cycle rise/fall strobes.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic inputclk,
  input  logic reset_b,
  input  logic async_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Shift the asynchronous pin through the synchronizer chain.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
    end
  end

  // Remember the previous synced level for edge detection.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      r_prev <= 1'b0;
    end else begin
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign level = r_sync[SYNC_STAGES-1];
  assign rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/nes_pad_emulator.sv
// Device-side NES controller: answers the host latch/shift-clock protocol
// with the live button state on an active-low serial data pin.
module nes_pad_emulator
  import nes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TMO_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 inputclk,
  input  logic                 reset_b,
  input  logic [NES_BITS-1:0]  buttons,
  input  logic                 clklatch,
  input  logic                 clkout,
  output logic                 data,
  output logic                 frame_done,
  output logic                 host_active,
  output logic [BIT_IDX_W-1:0] bit_index
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);

  logic w_lat_level;
  logic w_lat_rise;
  logic w_lat_fall;
  logic w_clk_level;
  logic w_clk_rise;
  logic w_clk_fall;
  logic w_unused;

  pad_state_t           r_state;
  logic [NES_BITS-1:0]  r_sr;
  logic                 r_data;
  logic                 r_frame_done;
  logic [BIT_IDX_W-1:0] r_bit_index;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic                 r_host_active;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
    .inputclk (inputclk),
    .reset_b  (reset_b),
    .async_in (clklatch),
    .level    (w_lat_level),
    .rise     (w_lat_rise),
    .fall     (w_lat_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
    .inputclk (inputclk),
    .reset_b  (reset_b),
    .async_in (clkout),
    .level    (w_clk_level),
    .rise     (w_clk_rise),
    .fall     (w_clk_fall)
  );

  // Only the rising edge of the shift clock matters to the pad.
  assign w_unused = w_clk_level ^ w_clk_fall;

  // Pad FSM: parallel load while latched, shift on clock edges, drain after 8 bits.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      r_state      <= DRAINED;
      r_sr         <= '0;
      r_data       <= 1'b1;
      r_frame_done <= 1'b0;
      r_bit_index  <= IDX_DRAINED;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        DRAINED: begin
          if (w_lat_level) begin
            r_state     <= LOAD;
            r_sr        <= buttons;
            r_data      <= ~buttons[BTN_A];
            r_bit_index <= IDX_FIRST;
          end else begin
            r_data      <= 1'b1;
            r_bit_index <= IDX_DRAINED;
          end
        end
        LOAD: begin
          // Parallel mode: shift clocks are ignored; the lat_fall cycle's load is the snapshot.
          r_sr        <= buttons;
          r_data      <= ~buttons[BTN_A];
          r_bit_index <= IDX_FIRST;
          if (w_lat_fall) begin
            r_state <= SHIFT;
          end else begin
            r_state <= LOAD;
          end
        end
        SHIFT: begin
          if (w_lat_rise) begin
            r_state     <= LOAD;
            r_sr        <= buttons;
            r_data      <= ~buttons[BTN_A];
            r_bit_index <= IDX_FIRST;
          end else if (w_clk_rise) begin
            r_sr <= {1'b0, r_sr[NES_BITS-1:1]};
            if (r_bit_index == IDX_LAST) begin
              r_state      <= DRAINED;
              r_data       <= 1'b1;
              r_bit_index  <= IDX_DRAINED;
              r_frame_done <= 1'b1;
            end else begin
              r_data      <= ~r_sr[1];
              r_bit_index <= r_bit_index + 4'd1;
            end
          end else begin
            r_data <= ~r_sr[0];
          end
        end
        default: begin
          r_state     <= DRAINED;
          r_data      <= 1'b1;
          r_bit_index <= IDX_DRAINED;
        end
      endcase
    end
  end

  // Latch-activity watchdog: clear on each latch rise, saturate at the timeout.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      r_tmo_cnt <= TMO_MAX;
    end else if (w_lat_rise) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt < TMO_MAX) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
    end else begin
      r_tmo_cnt <= TMO_MAX;
    end
  end

  // Registered host-present flag derived from the watchdog count.
  always_ff @(posedge inputclk or negedge reset_b) begin
    if (!reset_b) begin
      r_host_active <= 1'b0;
    end else begin
      r_host_active <= (r_tmo_cnt < TMO_MAX);
    end
  end

  assign data        = r_data;
  assign frame_done  = r_frame_done;
  assign bit_index   = r_bit_index;
  assign host_active = r_host_active;

endmodule

// File: tb/tb_nes_pad_emulator.sv
// Directed bench for nes_pad_emulator: table of full frames plus
// hand-written sequences for abort, overlap, overrun, timeout and reset.
module tb_nes_pad_emulator;

  localparam int HALF_US6  = 300;  // 6 us at 50 MHz
  localparam int LATCH_CYC = 600;  // 12 us at 50 MHz

  logic       clk = 1'b0;
  logic       reset_b;
  logic [7:0] buttons;
  logic       clklatch;
  logic       clkout;
  logic       data;
  logic       frame_done;
  logic       host_active;
  logic [3:0] bit_index;

  int n_cmp = 0;
  int n_err = 0;
  int fd_cnt = 0;

  typedef struct packed {
    logic [7:0] btn;
    logic [7:0] exp_data;  // bit i = data level before the i-th rising clock
  } vec_t;

  vec_t vecs [5];

  nes_pad_emulator #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (1000)
  ) dut (
    .inputclk    (clk),
    .reset_b     (reset_b),
    .buttons     (buttons),
    .clklatch    (clklatch),
    .clkout      (clkout),
    .data        (data),
    .frame_done  (frame_done),
    .host_active (host_active),
    .bit_index   (bit_index)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic latch_pulse();
    clklatch = 1'b1;
    wait_neg(LATCH_CYC);
    clklatch = 1'b0;
    wait_neg(HALF_US6);
  endtask

  task automatic clock_bit(output logic d);
    d = data;
    clkout = 1'b1;
    wait_neg(HALF_US6);
    clkout = 1'b0;
    wait_neg(HALF_US6);
  endtask

  task automatic shift_frame(input string name, input logic [7:0] exp);
    logic d;
    for (int b = 0; b < 8; b++) begin
      clock_bit(d);
      check($sformatf("%s_bit%0d", name, b), int'(d), int'(exp[b]));
    end
  endtask

  initial begin
    int   fd0;
    logic d;

    vecs[0] = '{btn: 8'b0001_0001, exp_data: 8'b1110_1110};
    vecs[1] = '{btn: 8'h80,        exp_data: 8'h7F};
    vecs[2] = '{btn: 8'h00,        exp_data: 8'hFF};
    vecs[3] = '{btn: 8'hFF,        exp_data: 8'h00};
    vecs[4] = '{btn: 8'hA5,        exp_data: 8'h5A};

    reset_b  = 1'b0;
    buttons  = 8'h00;
    clklatch = 1'b0;
    clkout   = 1'b0;
    wait_neg(3);
    check("rst_data", int'(data), 1);
    check("rst_bit_index", int'(bit_index), 8);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_host_active", int'(host_active), 0);
    reset_b = 1'b1;
    wait_neg(5);
    check("idle_bit_index", int'(bit_index), 8);

    // Table of full frames.
    for (int i = 0; i < 5; i++) begin
      buttons = vecs[i].btn;
      fd0 = fd_cnt;
      latch_pulse();
      check($sformatf("v%0d_idx_loaded", i), int'(bit_index), 0);
      shift_frame($sformatf("v%0d", i), vecs[i].exp_data);
      check($sformatf("v%0d_frame_done", i), fd_cnt - fd0, 1);
      check($sformatf("v%0d_bit_index", i), int'(bit_index), 8);
      check($sformatf("v%0d_data_end", i), int'(data), 1);
    end

    // Frame followed by 4 extra clocks.
    buttons = 8'h11;
    fd0 = fd_cnt;
    latch_pulse();
    shift_frame("extra", 8'hEE);
    for (int k = 0; k < 4; k++) begin
      clock_bit(d);
      check($sformatf("extra_clk%0d_data", k), int'(d), 1);
    end
    check("extra_bit_index", int'(bit_index), 8);
    check("extra_frame_done", fd_cnt - fd0, 1);

    // Buttons change one cycle after the synced latch fall.
    buttons = 8'h01;
    fd0 = fd_cnt;
    clklatch = 1'b1;
    wait_neg(LATCH_CYC);
    clklatch = 1'b0;
    wait_neg(3);
    buttons = 8'hFF;
    wait_neg(HALF_US6 - 3);
    shift_frame("snap", 8'hFE);
    check("snap_frame_done", fd_cnt - fd0, 1);

    // Abort after 3 clocks, then a full frame.
    buttons = 8'h80;
    fd0 = fd_cnt;
    latch_pulse();
    for (int k = 0; k < 3; k++) begin
      clock_bit(d);
      check($sformatf("abort_pre%0d_data", k), int'(d), 1);
    end
    check("abort_idx_pre", int'(bit_index), 3);
    latch_pulse();
    check("abort_no_frame_done", fd_cnt - fd0, 0);
    check("abort_idx_reload", int'(bit_index), 0);
    shift_frame("abort_new", 8'h7F);
    check("abort_new_frame_done", fd_cnt - fd0, 1);

    // Latch fall and clock rise in the same cycle.
    buttons = 8'h01;
    fd0 = fd_cnt;
    clklatch = 1'b1;
    wait_neg(LATCH_CYC);
    clklatch = 1'b0;
    clkout   = 1'b1;
    wait_neg(HALF_US6);
    check("simul_data_A", int'(data), 0);
    check("simul_bit_index", int'(bit_index), 0);
    clkout = 1'b0;
    wait_neg(HALF_US6);
    shift_frame("simul", 8'hFE);
    check("simul_frame_done", fd_cnt - fd0, 1);

    // Host-activity timeout around the 1000-cycle boundary.
    clklatch = 1'b1;
    wait_neg(10);
    check("tmo_active_after_rise", int'(host_active), 1);
    wait_neg(980);
    check("tmo_active_before_limit", int'(host_active), 1);
    wait_neg(20);
    check("tmo_inactive_after_limit", int'(host_active), 0);
    clklatch = 1'b0;
    wait_neg(10);
    clklatch = 1'b1;
    wait_neg(10);
    check("tmo_active_again", int'(host_active), 1);
    clklatch = 1'b0;
    wait_neg(HALF_US6);

    // Reset pulsed mid-frame.
    buttons = 8'h00;
    latch_pulse();
    for (int k = 0; k < 3; k++) clock_bit(d);
    reset_b = 1'b0;
    #1;
    check("midrst_data", int'(data), 1);
    check("midrst_bit_index", int'(bit_index), 8);
    check("midrst_frame_done", int'(frame_done), 0);
    check("midrst_host_active", int'(host_active), 0);
    wait_neg(3);
    reset_b = 1'b1;
    wait_neg(3);
    for (int k = 0; k < 2; k++) begin
      clock_bit(d);
      check($sformatf("midrst_clk%0d_data", k), int'(d), 1);
    end
    check("midrst_drained_idx", int'(bit_index), 8);
    check("midrst_drained_data", int'(data), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
